// File: rtl/hyperbus_native_ram_if.sv
// rtl/hyperbus_native_ram_if.sv - Hyperbus native initiator/responder signal bundle
interface hyperbus_native_ram_if #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16
);
  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
  logic                       hbus_rrq;
  logic                       hbus_wrq;
  logic                       hbus_ready;
  logic                       hbus_valid;
  logic                       hbus_busy;

  // Initiator side (e.g. FIFO bridge)
  modport master (
    output hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    input  hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );

  // Responder side (this memory)
  modport slave (
    input  hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    output hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );
endinterface

// File: rtl/hyperbus_native_ram.sv
// rtl/hyperbus_native_ram.sv - Hyperbus native responder emulating HyperRAM timing over sync RAM
module hyperbus_native_ram #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int MEM_AW          = 10,
  parameter int LATENCY         = 6,
  parameter int RECOVERY        = 2
) (
  input  logic                 hbus_clk,
  input  logic                 hbus_rst,
  hyperbus_native_ram_if.slave hbus
);

  // One shared down-counter serves both the latency and the recovery phase,
  // so it only needs to hold max(LATENCY, RECOVERY) - 1.
  localparam int CNT_MAX = (LATENCY > RECOVERY) ? LATENCY : RECOVERY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATENCY,
    S_WRITE,
    S_READ,
    S_RECOVER
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [MEM_AW-1:0]          ptr_q, ptr_d;
  logic                       dir_rd_q, dir_rd_d;
  logic                       ready_q, ready_d;
  logic                       valid_q, valid_d;
  logic                       busy_q;
  logic [HBUS_DATA_WIDTH-1:0] dat_q;
  logic                       mem_we;
  logic                       mem_re;
  logic                       dir_req;

  // Storage is deliberately left without reset so it maps onto block RAM.
  logic [HBUS_DATA_WIDTH-1:0] mem [0:(2**MEM_AW)-1];

  // Address bits above MEM_AW alias onto the same RAM; they are intentionally dropped.
  logic unused_adr_hi;
  assign unused_adr_hi = ^hbus.hbus_adr_i;

  // Only the request matching the latched direction can end the burst.
  assign dir_req = dir_rd_q ? hbus.hbus_rrq : hbus.hbus_wrq;

  assign hbus.hbus_ready = ready_q;
  assign hbus.hbus_valid = valid_q;
  assign hbus.hbus_busy  = busy_q;
  assign hbus.hbus_dat_o = dat_q;

  // Next-state, next-counter/pointer and RAM strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    dir_rd_d = dir_rd_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Read has priority when both requests arrive together.
        if (hbus.hbus_rrq || hbus.hbus_wrq) begin
          ptr_d    = hbus.hbus_adr_i[MEM_AW-1:0];
          dir_rd_d = hbus.hbus_rrq;
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = S_LATENCY;
        end
      end

      S_LATENCY: begin
        if (!dir_req) begin
          cnt_d   = CNT_W'(RECOVERY - 1);
          state_d = S_RECOVER;
        end else if (cnt_q == '0) begin
          if (dir_rd_q) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WRITE: begin
        // ready is registered, so the edge on which wrq is seen low
        // still has ready high but must not commit anything.
        if (hbus.hbus_wrq) begin
          if (ready_q) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
          end
        end else begin
          ready_d = 1'b0;
          cnt_d   = CNT_W'(RECOVERY - 1);
          state_d = S_RECOVER;
        end
      end

      S_READ: begin
        // Reads one word ahead of the initiator; the surplus word is discarded.
        if (hbus.hbus_rrq) begin
          mem_re  = 1'b1;
          valid_d = 1'b1;
          ptr_d   = ptr_q + 1'b1;
        end else begin
          valid_d = 1'b0;
          cnt_d   = CNT_W'(RECOVERY - 1);
          state_d = S_RECOVER;
        end
      end

      S_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers and read data; reset abandons any burst immediately.
  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      dir_rd_q <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      dir_rd_q <= dir_rd_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d != S_IDLE);
      if (mem_re) begin
        dat_q <= mem[ptr_q];
      end
    end
  end

  // RAM write port.
  always_ff @(posedge hbus_clk) begin
    if (mem_we) begin
      mem[ptr_q] <= hbus.hbus_dat_i;
    end
  end

endmodule

// File: tb/tb_hyperbus_native_ram.sv
// tb/tb_hyperbus_native_ram.sv - Self-checking bench for hyperbus_native_ram
module tb_hyperbus_native_ram;

  localparam int AW       = 32;
  localparam int DW       = 16;
  localparam int MEM_AW   = 4;
  localparam int DEPTH    = 1 << MEM_AW;
  localparam int LATENCY  = 6;
  localparam int RECOVERY = 2;

  logic hbus_clk;
  logic hbus_rst;

  hyperbus_native_ram_if #(.HBUS_ADDR_WIDTH(AW), .HBUS_DATA_WIDTH(DW)) bus ();

  hyperbus_native_ram #(
    .HBUS_ADDR_WIDTH(AW),
    .HBUS_DATA_WIDTH(DW),
    .MEM_AW         (MEM_AW),
    .LATENCY        (LATENCY),
    .RECOVERY       (RECOVERY)
  ) dut (
    .hbus_clk(hbus_clk),
    .hbus_rst(hbus_rst),
    .hbus    (bus)
  );

  // Free-running clock.
  initial hbus_clk = 1'b0;
  always #5 hbus_clk = ~hbus_clk;

  typedef struct {
    bit          wr;
    bit          both;
    logic [31:0] adr;
    int          len;
    bit          fixed;
    logic [15:0] d0;
    logic [15:0] d1;
    int          exp_lat;
  } vec_t;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wdata [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int widx(input logic [31:0] adr, input int k);
    logic [31:0] s;
    s = adr + 32'(k);
    return int'(s) & (DEPTH - 1);
  endfunction

  // Count edges until busy falls after the initiator dropped its request.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.hbus_busy && n < 50) begin
      @(posedge hbus_clk); #1;
      n++;
    end
    chk(name, n, RECOVERY + 1);
  endtask

  // Initiator model: presents wdata, advances whenever ready was high at an edge.
  task automatic write_burst(input logic [31:0] adr, input int exp_lat);
    int  k, edges, first, n;
    bit  r;
    n = wdata.size();
    k = 0; edges = 0; first = -1;
    @(posedge hbus_clk); #1;
    bus.hbus_adr_i = adr;
    bus.hbus_dat_i = wdata[0];
    bus.hbus_wrq   = 1'b1;
    while (k < n && edges < 300) begin
      r = bus.hbus_ready;
      @(posedge hbus_clk); #1;
      edges++;
      if (edges == 1) chk("wr_busy_after_req", bus.hbus_busy, 1);
      if (r) begin
        if (first < 0) first = edges - 1;
        ref_mem[widx(adr, k)] = wdata[k];
        k++;
        if (k < n) bus.hbus_dat_i = wdata[k];
        else begin
          bus.hbus_wrq   = 1'b0;
          bus.hbus_dat_i = DW'($urandom);
        end
      end
    end
    bus.hbus_wrq = 1'b0;
    chk("wr_words_done", k, n);
    chk("wr_first_accept_edge", first, exp_lat);
    chk("wr_ready_tail", bus.hbus_ready, 1);
    wait_idle("wr_recover_len");
    chk("wr_ready_idle", bus.hbus_ready, 0);
  endtask

  // Initiator model: collects n valid words then drops rrq.
  task automatic read_burst(input logic [31:0] adr, input int n, input bit hold_wrq, input int exp_lat);
    int          k, edges, first;
    logic [DW-1:0] last;
    k = 0; edges = 0; first = -1; last = '0;
    @(posedge hbus_clk); #1;
    bus.hbus_adr_i = adr;
    bus.hbus_rrq   = 1'b1;
    if (hold_wrq) begin
      bus.hbus_wrq   = 1'b1;
      bus.hbus_dat_i = DW'($urandom);
    end
    while (k < n && edges < 300) begin
      @(posedge hbus_clk); #1;
      edges++;
      if (edges == 1) chk("rd_busy_after_req", bus.hbus_busy, 1);
      if (hold_wrq) bus.hbus_dat_i = DW'($urandom);
      if (bus.hbus_valid) begin
        if (first < 0) first = edges - 1;
        chk("rd_data", bus.hbus_dat_o, ref_mem[widx(adr, k)]);
        last = bus.hbus_dat_o;
        k++;
      end
    end
    bus.hbus_rrq = 1'b0;
    bus.hbus_wrq = 1'b0;
    chk("rd_words_done", k, n);
    chk("rd_first_valid_edge", first, exp_lat);
    wait_idle("rd_recover_len");
    chk("rd_valid_idle", bus.hbus_valid, 0);
    chk("rd_dat_hold", bus.hbus_dat_o, last);
  endtask

  // Request that is withdrawn during the latency phase.
  task automatic abort_burst(input bit wr, input int drop_after);
    bit saw;
    saw = 1'b0;
    @(posedge hbus_clk); #1;
    bus.hbus_adr_i = $urandom;
    if (wr) begin
      bus.hbus_wrq   = 1'b1;
      bus.hbus_dat_i = DW'($urandom);
    end else begin
      bus.hbus_rrq = 1'b1;
    end
    repeat (drop_after) begin
      @(posedge hbus_clk); #1;
      saw = saw | bus.hbus_valid | bus.hbus_ready;
    end
    bus.hbus_rrq = 1'b0;
    bus.hbus_wrq = 1'b0;
    wait_idle("abort_recover_len");
    chk("abort_no_transfer", saw, 0);
  endtask

  vec_t vecs [$];

  initial begin
    vec_t v;
    bit   r;
    int   guard;
    logic [15:0] d0, d1;

    bus.hbus_adr_i = '0;
    bus.hbus_dat_i = '0;
    bus.hbus_rrq   = 1'b0;
    bus.hbus_wrq   = 1'b0;
    hbus_rst       = 1'b1;
    repeat (3) @(posedge hbus_clk);
    #1;
    chk("rst_ready", bus.hbus_ready, 0);
    chk("rst_valid", bus.hbus_valid, 0);
    chk("rst_busy",  bus.hbus_busy, 0);
    chk("rst_dat_o", bus.hbus_dat_o, 0);
    hbus_rst = 1'b0;

    // Directed table, then randomized entries.
    vecs.push_back('{1, 0, 32'h0,   DEPTH, 0, 16'h0,    16'h0,    LATENCY + 1});
    vecs.push_back('{1, 0, 32'h10,  2,     1, 16'hA5A5, 16'h5A5A, LATENCY + 1});
    vecs.push_back('{0, 0, 32'h10,  2,     0, 16'h0,    16'h0,    LATENCY + 1});
    vecs.push_back('{1, 0, 32'hF,   3,     0, 16'h0,    16'h0,    LATENCY + 1});
    vecs.push_back('{0, 0, 32'hF,   3,     0, 16'h0,    16'h0,    LATENCY + 1});
    vecs.push_back('{0, 1, 32'h7,   5,     0, 16'h0,    16'h0,    LATENCY + 1});
    vecs.push_back('{1, 0, 32'h123, 20,    0, 16'h0,    16'h0,    LATENCY + 1});
    vecs.push_back('{0, 0, 32'h0,   DEPTH, 0, 16'h0,    16'h0,    LATENCY + 1});
    for (int i = 0; i < 8; i++) begin
      v.wr      = bit'($urandom_range(0, 1));
      v.both    = v.wr ? 1'b0 : bit'($urandom_range(0, 1));
      v.adr     = $urandom;
      v.len     = $urandom_range(1, 8);
      v.fixed   = 1'b0;
      v.d0      = '0;
      v.d1      = '0;
      v.exp_lat = LATENCY + 1;
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.wr) begin
        wdata.delete();
        for (int k = 0; k < v.len; k++) begin
          if (v.fixed) wdata.push_back((k == 0) ? v.d0 : v.d1);
          else wdata.push_back(DW'($urandom));
        end
        write_burst(v.adr, v.exp_lat);
      end else begin
        read_burst(v.adr, v.len, v.both, v.exp_lat);
      end
    end

    // Requests withdrawn during latency, including on the last latency edge.
    abort_burst(1'b0, 3);
    abort_burst(1'b1, 2);
    abort_burst(1'b0, LATENCY);
    abort_burst(1'b1, LATENCY);
    read_burst(32'h0, DEPTH, 1'b0, LATENCY + 1);

    // Reset asserted right after the first word of a write burst was accepted.
    d0 = 16'hC3C3;
    d1 = 16'h3C3C;
    @(posedge hbus_clk); #1;
    bus.hbus_adr_i = 32'h5;
    bus.hbus_dat_i = d0;
    bus.hbus_wrq   = 1'b1;
    guard = 0;
    do begin
      r = bus.hbus_ready;
      @(posedge hbus_clk); #1;
      guard++;
    end while (!r && guard < 50);
    chk("rst_burst_first_edge", guard, LATENCY + 2);
    ref_mem[5]     = d0;
    bus.hbus_dat_i = d1;
    hbus_rst       = 1'b1;
    #1;
    chk("midrst_ready", bus.hbus_ready, 0);
    chk("midrst_valid", bus.hbus_valid, 0);
    chk("midrst_busy",  bus.hbus_busy, 0);
    chk("midrst_dat_o", bus.hbus_dat_o, 0);
    @(posedge hbus_clk); #1;
    bus.hbus_wrq = 1'b0;
    hbus_rst     = 1'b0;
    read_burst(32'h0, DEPTH, 1'b0, LATENCY + 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
